seq_divider: RTL

//   Multi-cycle restoring divider for the sequential 8-bit ALU datapath.

---
 rtl/seq_divider.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Results are held stable until the next accepted start.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's-complement operands,
// extra SIGN cycle applies the result signs).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             div_done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
`ifdef SEQ_DIVIDER_SIGNED_EN
    SIGN = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_sh, r_sh, dvs;
  logic [CW-1:0]    count;
  logic             dz_pend;
  logic             accept, last_step;
  logic [WIDTH:0]   r_shift, r_diff;
  logic [WIDTH-1:0] q_step, r_step;
  logic [WIDTH-1:0] a_mag, b_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_q, neg_r;

  // Magnitudes of the signed operands; the core divides them unsigned.
  always_comb begin
    a_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
    b_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
  end
`else
  // Unsigned operands feed the core directly.
  always_comb begin
    a_mag = dividend;
    b_mag = divisor;
  end
`endif

  // One restoring step: shift, trial subtract at WIDTH+1 bits, restore on borrow.
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    last_step = (state == RUN) && !dz_pend && (count == CW'(WIDTH - 1));
    r_shift   = {r_sh, q_sh[WIDTH-1]};
    r_diff    = r_shift - {1'b0, dvs};
    r_step    = r_diff[WIDTH] ? r_shift[WIDTH-1:0] : r_diff[WIDTH-1:0];
    q_step    = {q_sh[WIDTH-2:0], ~r_diff[WIDTH]};
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN: begin
        if (dz_pend) begin
          state_nx = DONE;
        end else if (last_step) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_nx = SIGN;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      SIGN: state_nx = DONE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Datapath: operand capture, shift/subtract iterations and result registers.
  // A zero divisor parks the raw dividend in r_sh so the single RUN cycle can
  // publish it as the remainder without a separate holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_sh        <= '0;
      r_sh        <= '0;
      dvs         <= '0;
      count       <= '0;
      dz_pend     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      div_done    <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      dvs         <= b_mag;
      dz_pend     <= (divisor == '0);
      r_sh        <= (divisor == '0) ? dividend : '0;
      q_sh        <= (divisor == '0) ? '0 : a_mag;
      count       <= '0;
      busy        <= (divisor != '0);
      div_done    <= 1'b0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q       <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r       <= dividend[WIDTH-1];
`endif
    end else if (state == RUN) begin
      if (dz_pend) begin
        quotient    <= '1;
        remainder   <= r_sh;
        div_by_zero <= 1'b1;
        div_done    <= 1'b1;
        busy        <= 1'b0;
        dz_pend     <= 1'b0;
      end else begin
        r_sh  <= r_step;
        q_sh  <= q_step;
        count <= count + 1'b1;
`ifndef SEQ_DIVIDER_SIGNED_EN
        if (last_step) begin
          quotient  <= q_step;
          remainder <= r_step;
          busy      <= 1'b0;
          div_done  <= 1'b1;
        end
`endif
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
    end else if (state == SIGN) begin
      quotient  <= neg_q ? ('0 - q_sh) : q_sh;
      remainder <= neg_r ? ('0 - r_sh) : r_sh;
      busy      <= 1'b0;
      div_done  <= 1'b1;
`endif
    end
  end

endmodule
